// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - Simon z-sequence table, rotate helper and key-reverse FSM states
package simon_pkg;

  // Bit i of Z_TAB[j] is z_j[i]; each sequence has period 62.
  localparam logic [4:0][61:0] Z_TAB = {
    62'h3DC94C3A046D678B,
    62'h3C2CE51207A635DB,
    62'h3369F885192C0EF5,
    62'h16864FB8AD0C9F71,
    62'h19C3522FB386A45F
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_REV,
    ST_DONE
  } state_e;

  function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
    logic [63:0] mask;
    mask = (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    return ((x >> r) | (x << (n - r))) & mask;
  endfunction

endpackage

// File: rtl/simon_ks_step.sv
// rtl/simon_ks_step.sv - one Simon key-schedule step, forward (dir_i=0) or inverse (dir_i=1)
module simon_ks_step
  import simon_pkg::*;
#(
  parameter int N = 64,
  parameter int M = 4
) (
  input  logic [M-1:0][N-1:0] win_i,
  input  logic                z_i,
  input  logic                dir_i,
  output logic [N-1:0]        word_o
);

  logic [N-1:0] a, b, t1, t2, sum;

  // Inverse step sees the window one word higher, so its f() taps move down by one.
  always_comb begin
    a      = dir_i ? win_i[M-2] : win_i[M-1];
    b      = (M == 4) ? (dir_i ? win_i[0] : win_i[1]) : '0;
    t1     = N'(ror(64'(a), 3, N)) ^ b;
    t2     = t1 ^ N'(ror(64'(t1), 1, N));
    sum    = t2 ^ {{(N-1){1'b0}}, z_i} ^ N'(3);
    word_o = dir_i ? ~(win_i[M-1] ^ sum) : (~win_i[0] ^ sum);
  end

endmodule

// File: rtl/simon_rkey_reverse.sv
// rtl/simon_rkey_reverse.sv - Simon round keys k[T-1]..k[0] for decryption; optional SIMON_RKEY_SELFCHECK_EN
module simon_rkey_reverse
  import simon_pkg::*;
#(
  parameter int N = 64,
  parameter int M = 4,
  parameter int T = 72,
  parameter int J = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M*N-1:0] key,
  output logic           busy,
  output logic [N-1:0]   rk,
  output logic [7:0]     rk_idx,
  output logic           rk_valid,
  input  logic           rk_ready,
  output logic           rk_last,
  output logic           done,
  output logic           err
);

  localparam logic [7:0] IDX_TOP  = 8'(T - 1);
  localparam logic [7:0] IDX_M    = 8'(M);
  localparam logic [7:0] FWD_LAST = 8'(T - M - 1);
  localparam logic [5:0] ZI_MAX   = 6'd61;

  state_e              state_q, state_d;
  logic [M-1:0][N-1:0] win_q, win_d;
  logic [7:0]          i_q, i_d, idx_q, idx_d;
  logic [5:0]          zi_q, zi_d, zi_dec, zi_sel;
  logic                step_dir, step_z;
  logic [N-1:0]        step_word, fill_word;

  assign zi_dec   = (zi_q == 6'd0) ? ZI_MAX : zi_q - 6'd1;
  assign step_dir = (state_q == ST_REV);
  assign zi_sel   = step_dir ? zi_dec : zi_q;
  assign step_z   = Z_TAB[J][zi_sel];

  simon_ks_step #(.N(N), .M(M)) u_step (
    .win_i  (win_q),
    .z_i    (step_z),
    .dir_i  (step_dir),
    .word_o (step_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      i_q     <= '0;
      zi_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      i_q     <= i_d;
      zi_q    <= zi_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    i_d       = i_q;
    zi_d      = zi_q;
    idx_d     = idx_q;
    fill_word = (idx_q >= IDX_M) ? step_word : '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          win_d   = key;
          i_d     = '0;
          zi_d    = '0;
          state_d = ST_FWD;
        end
      end
      ST_FWD: begin
        win_d = {step_word, win_q[M-1:1]};
        zi_d  = (zi_q == ZI_MAX) ? 6'd0 : zi_q + 6'd1;
        i_d   = i_q + 8'd1;
        if (i_q == FWD_LAST) begin
          idx_d   = IDX_TOP;
          state_d = ST_REV;
        end
      end
      ST_REV: begin
        // Below rk_idx==M the window already holds k[0..M-1]; it only shifts out.
        if (rk_ready) begin
          win_d = {win_q[M-2:0], fill_word};
          if (idx_q >= IDX_M) zi_d = zi_dec;
          idx_d = idx_q - 8'd1;
          if (idx_q == 8'd0) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy     = (state_q == ST_FWD) || (state_q == ST_REV);
  assign rk       = win_q[M-1];
  assign rk_idx   = idx_q;
  assign rk_valid = step_dir;
  assign rk_last  = step_dir && (idx_q == 8'd0);
  assign done     = (state_q == ST_DONE);

`ifdef SIMON_RKEY_SELFCHECK_EN
  logic [M*N-1:0] shadow_q;
  logic           err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      shadow_q <= key;
      err_q    <= 1'b0;
    end else if (step_dir && idx_q == IDX_M - 8'd1 && win_q != shadow_q) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
